mult_scheduler: RTL

MULT_SCHEDULER -- requirements
Module: mult_scheduler

---
 rtl/mult_scheduler_pkg.sv | 19 +
 rtl/mult_engine.sv | 61 ++++++
 rtl/mult_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/mult_scheduler_pkg.sv
// Shared definitions for the two-requester multiply scheduler.
//   state_t    : controller states (IDLE, RUN, HOLD)
//   ID_W       : requester index width
//   step_w()   : step counter width for an N-step shift-add engine
package mult_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned ID_W = 1;

    function automatic int unsigned step_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mult_engine.sv
// Sequential shift-add multiplier, one multiplicand bit per cycle.
//   clk, rst : clock, async active-high reset
//   start    : load a/b, clear accumulator and step counter
//   a, b     : multiplier (M bits) and multiplicand (N bits)
//   busy     : a job is stepping
//   done     : this cycle is the final step (product valid after this edge)
//   product  : accumulator, exact M+N bit result once busy falls
module mult_engine
    import mult_scheduler_pkg::*;
#(
    parameter int unsigned M = 3,
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [M+N-1:0] product
);

    localparam int unsigned W  = M + N;
    localparam int unsigned CW = step_w(N);

    logic [W-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] step_q;

    // Last step is known from the counter alone, so latency never depends on operands.
    assign done    = busy && (step_q == CW'(N - 1));
    assign product = acc_q;

    // Operands shift each step: a_q holds a << i, b_q[0] holds b[i].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            a_q    <= W'(a);
            b_q    <= b;
            acc_q  <= '0;
            step_q <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc_q  <= acc_q + (b_q[0] ? a_q : '0);
            a_q    <= a_q << 1;
            b_q    <= b_q >> 1;
            step_q <= step_q + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter and controller sharing one mult_engine between two requesters.
//   clk, rst                        : clock, async active-high reset
//   req0_valid/a/b, req0_ready      : requester 0 job handshake (ready combinational)
//   req1_valid/a/b, req1_ready      : requester 1 job handshake (ready combinational)
//   res_valid/product/id, res_ready : held result and consumer handshake
module mult_scheduler
    import mult_scheduler_pkg::*;
#(
    parameter int unsigned M = 3,
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [M-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [M-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    output logic            req1_ready,
    output logic            res_valid,
    output logic [M+N-1:0]  res_product,
    output logic [ID_W-1:0] res_id,
    input  logic            res_ready
);

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] grant_id_c;
    logic            grant_any_c;
    logic            accept_c;
    logic [M-1:0]    eng_a_c;
    logic [N-1:0]    eng_b_c;
    logic            eng_busy;
    logic            eng_done;

    // Arbitration, ready generation and next state.
    always_comb begin
        state_d     = state_q;
        grant_id_c  = '0;
        grant_any_c = req0_valid | req1_valid;
        accept_c    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        // On a tie the requester not served last wins.
        if (req0_valid && req1_valid) begin
            grant_id_c = (last_q == '0) ? ID_W'(1) : '0;
        end else if (req1_valid) begin
            grant_id_c = ID_W'(1);
        end

        accept_c   = (state_q == IDLE) && !rst && !eng_busy && grant_any_c;
        req0_ready = accept_c && (grant_id_c == '0);
        req1_ready = accept_c && (grant_id_c == ID_W'(1));

        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (eng_done)  state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    assign eng_a_c = (grant_id_c == ID_W'(1)) ? req1_a : req0_a;
    assign eng_b_c = (grant_id_c == ID_W'(1)) ? req1_b : req0_b;

    // State, pointer and result flags; the product is held by the engine accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= ID_W'(1);
            res_valid <= 1'b0;
            res_id    <= '0;
        end else begin
            state_q   <= state_d;
            res_valid <= (state_d == HOLD);
            if (accept_c) begin
                last_q <= grant_id_c;
                res_id <= grant_id_c;
            end
        end
    end

    mult_engine #(
        .M (M),
        .N (N)
    ) u_engine (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_c),
        .a       (eng_a_c),
        .b       (eng_b_c),
        .busy    (eng_busy),
        .done    (eng_done),
        .product (res_product)
    );

endmodule
